// File: rtl/register_file_pkg.sv
// Shared register-file types and sizes, reused by decode (read indices) and writeback (write port).
package register_file_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 6;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] reg_index_t;
  typedef logic [DATA_WIDTH-1:0] reg_word_t;
endpackage

// File: rtl/register_file.sv
// 64 x 32 general-purpose register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear of every entry.
module register_file
  import register_file_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] Read_Address_0,
  input  logic [ADDR_WIDTH-1:0] Read_Address_1,
  input  logic [ADDR_WIDTH-1:0] Write_Address,
  input  logic [DATA_WIDTH-1:0] Write_Data,
  input  logic                  Write_Enable,
  output logic [DATA_WIDTH-1:0] Read_Data_0,
  output logic [DATA_WIDTH-1:0] Read_Data_1
);

  reg_word_t mem [DEPTH];

  // Reset wins over a coincident write; there is no hardwired-zero entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (Write_Enable) begin
      mem[Write_Address] <= Write_Data;
    end
  end

  // No write-to-read bypass: a same-address read shows the old word until the edge.
  assign Read_Data_0 = mem[Read_Address_0];
  assign Read_Data_1 = mem[Read_Address_1];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: driver pushes expected read-port pairs, a monitor pops and compares.
module tb_register_file;
  import register_file_pkg::*;

  logic                  clock;
  logic                  reset;
  logic [ADDR_WIDTH-1:0] Read_Address_0;
  logic [ADDR_WIDTH-1:0] Read_Address_1;
  logic [ADDR_WIDTH-1:0] Write_Address;
  logic [DATA_WIDTH-1:0] Write_Data;
  logic                  Write_Enable;
  logic [DATA_WIDTH-1:0] Read_Data_0;
  logic [DATA_WIDTH-1:0] Read_Data_1;

  logic [2*DATA_WIDTH-1:0] exp_q[$];
  string                   name_q[$];
  int                      n_compared = 0;
  int                      n_failed   = 0;

  register_file dut (
    .clock          (clock),
    .reset          (reset),
    .Read_Address_0 (Read_Address_0),
    .Read_Address_1 (Read_Address_1),
    .Write_Address  (Write_Address),
    .Write_Data     (Write_Data),
    .Write_Enable   (Write_Enable),
    .Read_Data_0    (Read_Data_0),
    .Read_Data_1    (Read_Data_1)
  );

  // Clock / reset: free-running 10 ns clock starting low, so rising edges fall at 5, 15, 25 ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: compares the read ports whenever an expectation is pending.
  initial begin
    logic [2*DATA_WIDTH-1:0] e;
    string nm;
    forever begin
      #1;
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_compared++;
        if (Read_Data_0 !== e[2*DATA_WIDTH-1:DATA_WIDTH]) begin
          n_failed++;
          $display("FAIL %s rd0: got %h expected %h", nm, Read_Data_0, e[2*DATA_WIDTH-1:DATA_WIDTH]);
        end
        n_compared++;
        if (Read_Data_1 !== e[DATA_WIDTH-1:0]) begin
          n_failed++;
          $display("FAIL %s rd1: got %h expected %h", nm, Read_Data_1, e[DATA_WIDTH-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic [ADDR_WIDTH-1:0] ra0, input logic [ADDR_WIDTH-1:0] ra1,
                       input logic [ADDR_WIDTH-1:0] wa, input logic [DATA_WIDTH-1:0] wd,
                       input logic we);
    @(negedge clock);
    Read_Address_0 = ra0;
    Read_Address_1 = ra1;
    Write_Address  = wa;
    Write_Data     = wd;
    Write_Enable   = we;
  endtask

  // Queue an expectation and hold inputs until the monitor has consumed it (bounded, before the next edge).
  task automatic expect_rd(input string nm, input logic [DATA_WIDTH-1:0] e0,
                           input logic [DATA_WIDTH-1:0] e1);
    int waited;
    #1;
    exp_q.push_back({e0, e1});
    name_q.push_back(nm);
    waited = 0;
    while (exp_q.size() > 0 && waited < 3) begin
      #1;
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_compared++;
      n_failed++;
      $display("FAIL %s timeout: got %0d pending expected 0 pending", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  initial begin
    reset          = 1'b0;
    Read_Address_0 = 6'd3;
    Read_Address_1 = 6'd5;
    Write_Address  = 6'd0;
    Write_Data     = '0;
    Write_Enable   = 1'b0;

    // 1. Reset held: every address reads zero
    expect_rd("reset_hold", 32'h0, 32'h0);

    // 2. Write r3 = 0xC0; no bypass before the edge
    drive(6'd3, 6'd5, 6'd3, 32'h0000_00C0, 1'b1);
    reset = 1'b1;
    expect_rd("w_r3_pre", 32'h0, 32'h0);
    drive(6'd3, 6'd5, 6'd3, 32'h0000_00C0, 1'b0);
    expect_rd("w_r3_post", 32'h0000_00C0, 32'h0);

    // 3. Write r5 = 0x338
    drive(6'd3, 6'd5, 6'd5, 32'h0000_0338, 1'b1);
    expect_rd("w_r5_pre", 32'h0000_00C0, 32'h0);
    drive(6'd3, 6'd5, 6'd5, 32'h0000_0338, 1'b0);
    expect_rd("w_r5_post", 32'h0000_00C0, 32'h0000_0338);

    // 4. Overwrite r3 = 0x3, then retarget RA0 with no write
    drive(6'd3, 6'd5, 6'd3, 32'h0000_0003, 1'b1);
    drive(6'd3, 6'd5, 6'd3, 32'h0000_0003, 1'b0);
    expect_rd("ovr_r3", 32'h0000_0003, 32'h0000_0338);
    Read_Address_0 = 6'd5;
    expect_rd("ra0_move", 32'h0000_0338, 32'h0000_0338);

    // Write-side inputs wiggling with WE=0 must not land
    drive(6'd3, 6'd5, 6'd5, 32'hDEAD_BEEF, 1'b0);
    Write_Address = 6'd3;
    drive(6'd3, 6'd5, 6'd3, 32'hCAFE_F00D, 1'b0);
    expect_rd("we0_hold", 32'h0000_0003, 32'h0000_0338);

    // 5. Asynchronous reset mid-cycle while a write is requested
    drive(6'd3, 6'd5, 6'd3, 32'hFFFF_FFFF, 1'b1);
    #1 reset = 1'b0;
    expect_rd("async_rst", 32'h0, 32'h0);
    drive(6'd3, 6'd5, 6'd3, 32'hFFFF_FFFF, 1'b1);
    expect_rd("rst_vs_we", 32'h0, 32'h0);
    drive(6'd2, 6'd3, 6'd3, 32'hFFFF_FFFF, 1'b0);
    reset = 1'b1;
    expect_rd("post_rst", 32'h0, 32'h0);

    // 6. Read-during-write on the same address, then hold with WE=0
    drive(6'd5, 6'd3, 6'd3, 32'h0000_0001, 1'b1);
    expect_rd("rdw_pre", 32'h0, 32'h0);
    drive(6'd5, 6'd3, 6'd3, 32'h0000_0001, 1'b0);
    expect_rd("rdw_post", 32'h0, 32'h0000_0001);
    drive(6'd5, 6'd3, 6'd3, 32'h0000_0001, 1'b0);
    expect_rd("rdw_hold", 32'h0, 32'h0000_0001);

    // Both ports on the register being written
    drive(6'd3, 6'd3, 6'd3, 32'h1234_5678, 1'b1);
    expect_rd("same_pre", 32'h0000_0001, 32'h0000_0001);
    drive(6'd3, 6'd3, 6'd3, 32'h1234_5678, 1'b0);
    expect_rd("same_post", 32'h1234_5678, 32'h1234_5678);

    // Boundary entries r0 and r63 are ordinary writable registers
    drive(6'd0, 6'd63, 6'd0, 32'hA5A5_A5A5, 1'b1);
    drive(6'd0, 6'd63, 6'd63, 32'h5A5A_5A5A, 1'b1);
    drive(6'd0, 6'd63, 6'd63, 32'h5A5A_5A5A, 1'b0);
    expect_rd("edge_regs", 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    Read_Address_0 = 6'd3;
    Read_Address_1 = 6'd5;
    expect_rd("others_kept", 32'h1234_5678, 32'h0);

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
